// File: rtl/t_skew_acc.sv
// Skew-code accumulator: averages N = 2^LOG2_N skew-sampler codes into sum/mean/min/max/span.
// Latency: result registered at the Nth accepted sample, 2+N clk_b edges after the start edge.
// Backpressure: the result is held in DONE until res_valid && res_ready; start is ignored while busy.
//
// Ports:
//   clk_b      in   1   sampling clock, the block is fully synchronous to it
//   rst_n      in   1   asynchronous active-low reset
//   skew_code  in   CW  binary skew code from the delay-chain sampler
//   start      in   1   request one measurement (level-sampled in IDLE only)
//   res_ready  in   1   consumer accepts the result
//   busy       out  1   measurement in progress or result pending (ARM, ACC, DONE)
//   res_valid  out  1   result available (DONE only)
//   res_mean   out  CW  res_sum >> LOG2_N, truncated
//   res_min    out  CW  smallest accepted code
//   res_max    out  CW  largest accepted code
//   res_span   out  CW  res_max - res_min
//   res_sum    out  SW  exact sum of the N accepted codes
//
// Every output comes straight from a register, so there is no input-to-output
// combinational path.

module t_skew_acc #(
    parameter  int STAGES = 64,
    parameter  int LOG2_N = 4,
    localparam int CW     = $clog2(STAGES + 1),
    localparam int SW     = CW + LOG2_N
) (
    input  logic          clk_b,
    input  logic          rst_n,
    input  logic [CW-1:0] skew_code,
    input  logic          start,
    input  logic          res_ready,
    output logic          busy,
    output logic          res_valid,
    output logic [CW-1:0] res_mean,
    output logic [CW-1:0] res_min,
    output logic [CW-1:0] res_max,
    output logic [CW-1:0] res_span,
    output logic [SW-1:0] res_sum
);

    localparam int               CNT_W    = LOG2_N + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_N) - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_arm_cnt;
    logic [CNT_W-1:0] r_cnt;
    logic [SW-1:0]    r_acc_sum;
    logic [CW-1:0]    r_acc_min;
    logic [CW-1:0]    r_acc_max;

    logic             r_busy;
    logic             r_res_valid;
    logic [CW-1:0]    r_res_mean;
    logic [CW-1:0]    r_res_min;
    logic [CW-1:0]    r_res_max;
    logic [CW-1:0]    r_res_span;
    logic [SW-1:0]    r_res_sum;

    logic             w_first;
    logic             w_last;
    logic [SW-1:0]    w_sum_nxt;
    logic [CW-1:0]    w_min_nxt;
    logic [CW-1:0]    w_max_nxt;
    logic [CW-1:0]    w_mean_nxt;
    logic [CW-1:0]    w_span_nxt;

    // Running statistics including the sample presented at this edge. The
    // first sample seeds sum/min/max directly, so nothing stale from a
    // previous or aborted measurement can leak in and no constant seed is
    // needed for min/max.
    always_comb begin
        w_first    = (r_cnt == '0);
        w_last     = (r_cnt == CNT_LAST);
        w_sum_nxt  = (w_first ? '0 : r_acc_sum) + SW'(skew_code);
        w_min_nxt  = (w_first || (skew_code < r_acc_min)) ? skew_code : r_acc_min;
        w_max_nxt  = (w_first || (skew_code > r_acc_max)) ? skew_code : r_acc_max;
        // The top LOG2_N bits of the shifted sum are always zero.
        w_mean_nxt = CW'(w_sum_nxt >> LOG2_N);
        w_span_nxt = w_max_nxt - w_min_nxt;
    end

    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_arm_cnt   <= 1'b0;
            r_cnt       <= '0;
            r_acc_sum   <= '0;
            r_acc_min   <= '0;
            r_acc_max   <= '0;
            r_busy      <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_mean  <= '0;
            r_res_min   <= '0;
            r_res_max   <= '0;
            r_res_span  <= '0;
            r_res_sum   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state   <= ARM;
                        r_busy    <= 1'b1;
                        r_arm_cnt <= 1'b0;
                        r_cnt     <= '0;
                    end
                end
                // Two edges of discarded codes flush the sampler's own
                // output register, which may still hold a pre-start code.
                ARM: begin
                    if (r_arm_cnt) begin
                        r_state   <= ACC;
                        r_arm_cnt <= 1'b0;
                    end else begin
                        r_arm_cnt <= 1'b1;
                    end
                end
                ACC: begin
                    r_acc_sum <= w_sum_nxt;
                    r_acc_min <= w_min_nxt;
                    r_acc_max <= w_max_nxt;
                    if (w_last) begin
                        r_state     <= DONE;
                        r_cnt       <= '0;
                        r_res_valid <= 1'b1;
                        r_res_sum   <= w_sum_nxt;
                        r_res_mean  <= w_mean_nxt;
                        r_res_min   <= w_min_nxt;
                        r_res_max   <= w_max_nxt;
                        r_res_span  <= w_span_nxt;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                // start is deliberately not looked at here: a request
                // coinciding with the handshake is only honoured once IDLE
                // samples it on the following edge.
                DONE: begin
                    if (res_ready) begin
                        r_state     <= IDLE;
                        r_busy      <= 1'b0;
                        r_res_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_busy      <= 1'b0;
                    r_res_valid <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign res_valid = r_res_valid;
    assign res_mean  = r_res_mean;
    assign res_min   = r_res_min;
    assign res_max   = r_res_max;
    assign res_span  = r_res_span;
    assign res_sum   = r_res_sum;

endmodule

// File: tb/tb_t_skew_acc.sv
// Testbench for t_skew_acc: directed measurements with a result scoreboard.
// Latency: checks result timing of 2+N edges after the start edge.
// Backpressure: exercises held results under res_ready=0 and back-to-back starts.

module tb_t_skew_acc;

    localparam int STAGES = 64;
    localparam int LOG2_N = 4;
    localparam int N      = 1 << LOG2_N;
    localparam int CW     = $clog2(STAGES + 1);
    localparam int SW     = CW + LOG2_N;

    logic          clk_b     = 1'b0;
    logic          rst_n     = 1'b0;
    logic [CW-1:0] skew_code = '0;
    logic          start     = 1'b0;
    logic          res_ready = 1'b1;
    logic          busy;
    logic          res_valid;
    logic [CW-1:0] res_mean;
    logic [CW-1:0] res_min;
    logic [CW-1:0] res_max;
    logic [CW-1:0] res_span;
    logic [SW-1:0] res_sum;

    t_skew_acc #(.STAGES(STAGES), .LOG2_N(LOG2_N)) dut (
        .clk_b     (clk_b),
        .rst_n     (rst_n),
        .skew_code (skew_code),
        .start     (start),
        .res_ready (res_ready),
        .busy      (busy),
        .res_valid (res_valid),
        .res_mean  (res_mean),
        .res_min   (res_min),
        .res_max   (res_max),
        .res_span  (res_span),
        .res_sum   (res_sum)
    );

    always #5 clk_b = ~clk_b;

    typedef struct {
        logic [SW-1:0] sum;
        logic [CW-1:0] mean;
        logic [CW-1:0] mn;
        logic [CW-1:0] mx;
        logic [CW-1:0] span;
    } exp_t;

    int            n_tests = 0;
    int            n_fail  = 0;
    exp_t          sb[$];
    exp_t          last_exp;
    logic [CW-1:0] codes[N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk_b);
        #1;
    endtask

    // Reference result of the codes[] about to be driven.
    task automatic push_model();
        exp_t          e;
        logic [SW-1:0] s;
        logic [CW-1:0] mn;
        logic [CW-1:0] mx;
        s  = '0;
        mn = codes[0];
        mx = codes[0];
        for (int i = 0; i < N; i++) begin
            s = s + SW'(codes[i]);
            if (codes[i] < mn) mn = codes[i];
            if (codes[i] > mx) mx = codes[i];
        end
        e.sum  = s;
        e.mean = CW'(s >> LOG2_N);
        e.mn   = mn;
        e.mx   = mx;
        e.span = mx - mn;
        sb.push_back(e);
    endtask

    task automatic check_hold(input string tag);
        chk({tag, "_sum"},  32'(res_sum),  32'(last_exp.sum));
        chk({tag, "_mean"}, 32'(res_mean), 32'(last_exp.mean));
        chk({tag, "_min"},  32'(res_min),  32'(last_exp.mn));
        chk({tag, "_max"},  32'(res_max),  32'(last_exp.mx));
        chk({tag, "_span"}, 32'(res_span), 32'(last_exp.span));
    endtask

    task automatic check_result(input string tag);
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s_sb: observed empty scoreboard expected one entry", tag);
        end else begin
            last_exp = sb.pop_front();
            chk({tag, "_valid"}, 32'(res_valid), 32'd1);
            chk({tag, "_busy"},  32'(busy),      32'd1);
            check_hold(tag);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"},  32'(busy),      32'd0);
        chk({tag, "_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_sum"},   32'(res_sum),   32'd0);
        chk({tag, "_mean"},  32'(res_mean),  32'd0);
        chk({tag, "_min"},   32'(res_min),   32'd0);
        chk({tag, "_max"},   32'(res_max),   32'd0);
        chk({tag, "_span"},  32'(res_span),  32'd0);
    endtask

    // One measurement: start edge E0, two ARM edges fed arm_code, then codes[].
    task automatic drive_meas(input string tag, input logic [CW-1:0] arm_code, input bit keep_start);
        int edges;
        push_model();
        start = 1'b1;
        tick();
        edges = 0;
        start = keep_start;
        skew_code = arm_code;
        tick();
        tick();
        edges += 2;
        chk({tag, "_busy_arm"}, 32'(busy), 32'd1);
        for (int i = 0; i < N; i++) begin
            skew_code = codes[i];
            if (i == N - 1) chk({tag, "_early_valid"}, 32'(res_valid), 32'd0);
            tick();
            edges++;
        end
        for (int k = 0; k < 40 && !res_valid; k++) begin
            tick();
            edges++;
        end
        chk({tag, "_latency"}, 32'(edges), 32'(2 + N));
        check_result(tag);
        skew_code = '0;
    endtask

    task automatic finish_hs(input string tag);
        res_ready = 1'b1;
        tick();
        chk({tag, "_hs_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_hs_busy"},  32'(busy),      32'd0);
        check_hold({tag, "_retained"});
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk_b);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        tick();
        check_zero("idle_after_reset");

        // Constant 10, one-cycle start
        for (int i = 0; i < N; i++) codes[i] = CW'(10);
        drive_meas("const10", CW'(10), 1'b0);
        finish_hs("const10");

        // Ramp 0..15 with 63 presented during ARM (must be discarded)
        for (int i = 0; i < N; i++) codes[i] = CW'(i);
        drive_meas("ramp", CW'(63), 1'b0);
        finish_hs("ramp");

        // Full scale: all codes equal STAGES
        for (int i = 0; i < N; i++) codes[i] = CW'(64);
        drive_meas("full", CW'(0), 1'b0);
        finish_hs("full");

        // Backpressure with start toggling while DONE; codes above STAGES included
        for (int i = 0; i < N; i++) codes[i] = CW'(127 - 5 * i);
        res_ready = 1'b0;
        drive_meas("bp", CW'(1), 1'b0);
        for (int c = 0; c < 5; c++) begin
            start = (c % 2 == 0);
            tick();
            chk("bp_hold_valid", 32'(res_valid), 32'd1);
            chk("bp_hold_busy",  32'(busy),      32'd1);
            check_hold("bp_hold");
        end
        start = 1'b1;
        res_ready = 1'b1;
        tick();
        chk("bp_hs_valid", 32'(res_valid), 32'd0);
        chk("bp_hs_busy",  32'(busy),      32'd0);
        start = 1'b0;
        tick();
        chk("bp_no_restart", 32'(busy), 32'd0);
        check_hold("bp_idle_retained");

        // Reset after the 7th accepted sample, then a clean constant-5 run
        start = 1'b1;
        tick();
        start = 1'b0;
        skew_code = CW'(99);
        tick();
        tick();
        for (int i = 0; i < 7; i++) begin
            skew_code = CW'(30);
            tick();
        end
        chk("abort_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_zero("abort");
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) codes[i] = CW'(5);
        drive_meas("after_abort", CW'(30), 1'b0);
        finish_hs("after_abort");

        // Back-to-back with start held high and res_ready=1
        for (int i = 0; i < N; i++) codes[i] = CW'($urandom_range(0, 127));
        drive_meas("b2b_first", CW'(7), 1'b1);
        finish_hs("b2b_first");
        for (int i = 0; i < N; i++) codes[i] = CW'($urandom_range(0, 127));
        drive_meas("b2b_second", CW'(120), 1'b1);
        start = 1'b0;
        finish_hs("b2b_second");
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
